// File: rtl/pwm_sample_sequencer.sv
// pwm_sample_sequencer: frame-synchronous sample scheduler for the PWM stage.
// Buffers filter samples in a small FIFO and releases one per PWM frame.
// Ports: Clk_pwm, Rst (sync, active high), SampleIn/SampleValid/SampleReady
//   (valid/ready input), SigVec (duty code, changes only at frame start),
//   FrameStrobe (last clock of frame), Underrun (empty-FIFO boundary pulse),
//   UnderrunSticky (latched underrun, cleared by Rst).
// Option: define PWM_SEQ_SOFTSTART_EN to ramp SigVec 0 -> MIDSCALE after reset.
module pwm_sample_sequencer #(
  parameter int         FIFO_DEPTH     = 4,
  parameter int         FRAME_BITS     = 11,
  parameter logic [9:0] MIDSCALE       = 10'd512,
  parameter int         PRIME_LEVEL    = 2,
  parameter int         UNDERRUN_LIMIT = 4,
  parameter logic [9:0] RAMP_STEP      = 10'd8
) (
  input  logic       Clk_pwm,
  input  logic       Rst,
  input  logic [9:0] SampleIn,
  input  logic       SampleValid,
  output logic       SampleReady,
  output logic [9:0] SigVec,
  output logic       FrameStrobe,
  output logic       Underrun,
  output logic       UnderrunSticky
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = $clog2(UNDERRUN_LIMIT + 1);

  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_LVL = CW'(PRIME_LEVEL);
  localparam logic [UW-1:0] UR_LAST   = UW'(UNDERRUN_LIMIT - 1);

  localparam logic [FRAME_BITS-1:0] CNT_LAST = '1;
  localparam logic [FRAME_BITS-1:0] CNT_PRE  =
    CNT_LAST - FRAME_BITS'(1);

  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
`ifdef PWM_SEQ_SOFTSTART_EN
  localparam logic [1:0] ST_RAMP   = 2'd0;
  localparam logic [1:0] ST_RESET  = ST_RAMP;
  localparam logic [9:0] SIG_RESET = 10'd0;
`else
  localparam logic [1:0] ST_RESET  = ST_PRIME;
  localparam logic [9:0] SIG_RESET = MIDSCALE;
`endif

  logic [9:0]            mem [FIFO_DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         countNxt;
  logic [FRAME_BITS-1:0] frameCnt;
  logic [1:0]            state;
  logic [1:0]            stateNxt;
  logic [UW-1:0]         urCnt;
  logic [UW-1:0]         urCntNxt;
  logic [9:0]            sigNxt;
  logic                  boundary;
  logic                  preBoundary;
  logic                  push;
  logic                  pop;
  logic                  urNxt;

  assign boundary    = frameCnt == CNT_LAST;
  assign preBoundary = frameCnt == CNT_PRE;
  assign SampleReady = count != FULL;
  assign push        = SampleValid & SampleReady;
  assign countNxt    = count + CW'(push) - CW'(pop);

  // Underrun is decided one cycle early so the registered pulse lines up
  // with the boundary cycle; state cannot change before that boundary.
  assign urNxt = preBoundary && (state == ST_RUN) &&
                 (countNxt == '0);

  always_comb begin
    pop      = 1'b0;
    stateNxt = state;
    sigNxt   = SigVec;
    urCntNxt = urCnt;
    if (boundary) begin
      unique case (1'b1)
`ifdef PWM_SEQ_SOFTSTART_EN
        (state == ST_RAMP): begin
          if (SigVec >= MIDSCALE - RAMP_STEP) begin
            sigNxt   = MIDSCALE;
            stateNxt = ST_PRIME;
          end else begin
            sigNxt = SigVec + RAMP_STEP;
          end
        end
`endif
        (state == ST_PRIME): begin
          if (count >= PRIME_LVL) begin
            pop      = 1'b1;
            sigNxt   = mem[rdPtr];
            stateNxt = ST_RUN;
            urCntNxt = '0;
          end
        end
        (state == ST_RUN): begin
          if (count != '0) begin
            pop      = 1'b1;
            sigNxt   = mem[rdPtr];
            urCntNxt = '0;
          end else if (urCnt == UR_LAST) begin
            sigNxt   = MIDSCALE;
            stateNxt = ST_PRIME;
            urCntNxt = '0;
          end else begin
            urCntNxt = urCnt + UW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk_pwm) begin
    if (Rst) begin
      frameCnt       <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      state          <= ST_RESET;
      urCnt          <= '0;
      SigVec         <= SIG_RESET;
      FrameStrobe    <= 1'b0;
      Underrun       <= 1'b0;
      UnderrunSticky <= 1'b0;
    end else begin
      frameCnt <= frameCnt + FRAME_BITS'(1);
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count          <= countNxt;
      state          <= stateNxt;
      urCnt          <= urCntNxt;
      SigVec         <= sigNxt;
      FrameStrobe    <= preBoundary;
      Underrun       <= urNxt;
      UnderrunSticky <= UnderrunSticky | urNxt;
    end
  end

  always_ff @(posedge Clk_pwm) begin
    if (push && !Rst) mem[wrPtr] <= SampleIn;
  end

endmodule

// File: doc/pwm_sample_sequencer.md
# pwm_sample_sequencer

Frame-synchronous sample scheduler for the 10-bit PWM output stage of the ANC audio path. Accepts processed samples from the adaptive filter over a valid/ready handshake and buffers them in a small FIFO. Presents exactly one sample per PWM frame on `SigVec`, updated at the frame boundary so the PWM comparator never sees a mid-frame change. Handles start-up priming, optional soft-start ramp, and underrun recovery.

## Interface
- `FIFO_DEPTH`, 4: sample buffer depth, power of two, 2..16.
- `FRAME_BITS`, 11: PWM frame length is 2^FRAME_BITS clocks; must match the PWM counter width.
- `MIDSCALE`, 10'd512: idle/silence output code.
- `PRIME_LEVEL`, 2: FIFO occupancy required before leaving PRIME.
- `UNDERRUN_LIMIT`, 4: consecutive underrun frames before falling back to PRIME.
- `RAMP_STEP`, 10'd8: soft-start increment per frame (used only with `PWM_SEQ_SOFTSTART_EN`).
- `Clk_pwm`  input  1  PWM clock; all logic on the rising edge.
- `Rst`  input  1  synchronous, active-high reset.
- `SampleIn`  input  10  unsigned offset-binary sample from the filter.
- `SampleValid`  input  1  `SampleIn` is valid.
- `SampleReady`  output  1  sequencer can accept a sample this cycle.
- `SigVec`  output  10  duty code to the PWM stage.
- `FrameStrobe`  output  1  one-cycle pulse on the last clock of each frame.
- `Underrun`  output  1  one-cycle pulse when a frame boundary finds the FIFO empty in RUN.
- `UnderrunSticky`  output  1  latched underrun indicator; cleared only by `Rst`.

## Operation
- Frame counter: FRAME_BITS-bit up counter, wraps from all-ones to 0. Boundary = counter all-ones; `FrameStrobe` is high in that cycle.
- Handshake: a transfer occurs when `SampleValid & SampleReady`. `SampleReady = !full`, computed from the registered occupancy. When full, ready stays 0 even if a pop happens in the same cycle. `SampleIn` is captured on transfer.
- FIFO: circular buffer with FIFO_DEPTH entries and a pointer-wrapped occupancy count from 0 to FIFO_DEPTH. A simultaneous push and pop leaves the count unchanged. Pops happen only at a boundary.
- States:
  - RAMP (macro only):
    - `SigVec` starts at 0.
    - Each boundary adds RAMP_STEP, saturating at MIDSCALE.
    - On the boundary where the value reaches MIDSCALE, go to PRIME.
    - Samples are accepted but not popped.
  - PRIME:
    - `SigVec` = MIDSCALE.
    - At a boundary with occupancy ≥ PRIME_LEVEL: pop the head into `SigVec` and go to RUN.
    - Otherwise stay in PRIME and hold MIDSCALE.
  - RUN:
    - At each boundary, if the FIFO is non-empty, pop into `SigVec` and clear the underrun run-count.
    - If the FIFO is empty:
      - hold the previous `SigVec`;
      - pulse `Underrun` and set `UnderrunSticky`;
      - increment the run-count.
    - When the run-count reaches UNDERRUN_LIMIT, set `SigVec` = MIDSCALE at that boundary and go to PRIME.
- A push arriving in the boundary cycle is not visible to that boundary's pop or PRIME check. The decision uses the registered occupancy.
- `Rst` mid-operation:
  - FIFO is flushed and the frame counter returns to 0.
  - State goes to the reset state and all outputs take their reset values on the next edge.
  - In-flight `SampleIn` is dropped.

## Timing
- Reset values:
  - `SigVec` = 0 with the macro, MIDSCALE without it.
  - `SampleReady` = 1.
  - `FrameStrobe`, `Underrun`, `UnderrunSticky` = 0.
  - Frame counter = 0.
  - Reset state = RAMP with the macro, PRIME without it.
- `SigVec` is registered. It changes only on the edge ending the boundary cycle, so the new code is in effect from frame count 0.
- Alignment: `Rst` is released in the same cycle the PWM counter is 0, so both counters stay in lockstep.
- Latency: a sample accepted at cycle t can appear no earlier than the edge after the next boundary strictly after t.
- `Underrun` and `FrameStrobe` are registered and assert in the boundary cycle itself, decoded from the counter and registered occupancy.
- Throughput: at most one pop per 2^FRAME_BITS clocks; up to one push per clock.

## Configuration
- `PWM_SEQ_SOFTSTART_EN`
  - Defined: RAMP state is compiled in. After reset, output ramps 0 → MIDSCALE in steps of RAMP_STEP, one step per frame (64 frames at defaults), then enters PRIME. Avoids the speaker pop at power-up.
  - Undefined: no RAMP logic. Reset enters PRIME with `SigVec` = MIDSCALE immediately.

## Test plan
- Prime and play:
  - Stimulus: macro off; reset; push 0x100, 0x200, 0x300 early in frame 0.
  - Required response: at boundary 0 (cycle 2047), `SigVec` becomes 0x100 from cycle 2048. It then becomes 0x200 at cycle 4096 and 0x300 at cycle 6144.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4; hold `SampleValid` high with an incrementing `SampleIn`.
  - Required response: exactly 4 transfers, then `SampleReady`=0 until the boundary pop. One further transfer follows, with no sample lost or duplicated.
- Underrun hold and fallback:
  - Stimulus: in RUN with last `SigVec`=0x2A0 and an empty FIFO.
  - Required response: `Underrun` pulses at the next 3 boundaries while `SigVec` holds 0x2A0, and `UnderrunSticky`=1. At the 4th boundary, `SigVec`=0x200 and the state is PRIME.
- Soft start:
  - Stimulus: macro on; reset; no samples pushed.
  - Required response: `SigVec` reads 0, 8, 16, … per frame, reaches 512 after 64 boundaries, then holds 512 in PRIME.
- Reset mid-frame:
  - Stimulus: assert `Rst` at frame count 1000 with 3 samples queued.
  - Required response: next edge gives counter 0, FIFO empty, `SigVec` at its reset value, `SampleReady`=1, `UnderrunSticky`=0.
- Boundary push race:
  - Stimulus: in PRIME with 1 sample queued; push a second sample in the boundary cycle.
  - Required response: stays in PRIME that frame, with `SigVec`=512. Enters RUN at the following boundary, outputting the first sample.
